prim_reg_bus_adapter: RTL and testbench
=======================================

Name: prim_reg_bus_adapter

Overview:
- Bus-side front end for a bank of prim_subreg instances. Accepts single-beat read/write requests on a valid/ready bus, checks each access against the per-register sw_access_e policy, and issues per-register we/re strobes plus byte-merged write data.
- Returns read data and an error flag on a valid/ready response channel.
- Sits between the peripheral bus bridge and the subreg bank of each peripheral register block. One transaction is outstanding at a time.

Parameters:
- NumRegs, 8, number of 32-bit registers in the bank (1..64).
- DW, 32, data width (fixed 32; the parameter exists for width expressions only).
- AW, 8, byte-address width; must satisfy 2^(AW-2) >= NumRegs.
- RegAccess, all SwAccessRW, array [NumRegs] of prim_subreg_pkg::sw_access_e giving the policy per register index.

Ports:
- clk_i  in  1  clock; all state is on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid && ready.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  AW  byte address.
- req_wdata_i  in  DW  write data.
- req_be_i  in  DW/8  byte enables (writes only).
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid && ready.
- rsp_rdata_o  out  DW  read data; 0 for writes and errors.
- rsp_error_o  out  1  access error.
- reg_we_o  out  NumRegs  one-hot write strobe.
- reg_re_o  out  NumRegs  one-hot read strobe.
- reg_wd_o  out  DW  merged write data, shared by all registers.
- reg_qs_i  in  NumRegs*DW  current register values, flattened; register i occupies bits [i*DW +: DW].

Behaviour:
- Reset is synchronous and active-high on clk_i. While rst_i is high:
  - state = IDLE.
  - All outputs are 0, including req_ready_o.
  - Captured request fields are cleared.
- Reset asserted in any state aborts the transaction. No strobe appears in the cycle after reset is sampled, and no response is produced for an aborted transaction.
- FSM states are IDLE, ACCESS and RESP.
  - IDLE: req_ready_o = 1. On accept, capture write, addr, wdata and be, then go to ACCESS.
  - ACCESS (exactly one cycle): req_ready_o = 0. Drive strobes per the decode rules below, capture rsp_rdata/rsp_error into registers, then go to RESP.
  - RESP: rsp_valid_o = 1 and rsp_rdata_o/rsp_error_o are stable. When rsp_ready_i = 1, go to IDLE. Otherwise hold.
- Latency and throughput:
  - Accept cycle T: strobes in T+1, rsp_valid_o first high in T+2.
  - Minimum 3 cycles per transaction.
  - A new request is never accepted in the cycle its predecessor's response completes; req_ready_o rises the following cycle.
- Address decode: idx = addr[AW-1:2].
  - addr[1:0] != 0, or idx >= NumRegs, means decode error: no strobes, error = 1, rdata = 0.
- Write to a decoded register:
  - RO or RC: error = 1, no strobe.
  - be == 0: no strobe, error = 0.
  - Otherwise reg_we_o[idx] = 1 and error = 0.
- reg_wd_o byte merge, per byte b:
  - RW or WO: wdata byte if be[b], else qs[idx] byte.
  - W1C or W1S: wdata byte if be[b], else 0x00.
  - W0C: wdata byte if be[b], else 0xFF.
- Read of a decoded register:
  - reg_re_o[idx] = 1 for every policy.
  - rdata = qs[idx], sampled in the ACCESS cycle (the pre-clear value for RC).
  - WO returns rdata = 0 with error = 0.
- Strobe and bus rules:
  - reg_we_o and reg_re_o are zero outside ACCESS and never both nonzero.
  - reg_wd_o = 0 outside a write ACCESS cycle.
- req_* inputs are ignored when req_ready_o = 0; no reliance on their stability.
- Elaboration assertions: NumRegs <= 2^(AW-2) and DW == 32.

Decomposition:
- sw_access_e stays in prim_subreg_pkg, which is imported.
- The adapter state enum (IDLE/ACCESS/RESP) lives in a new prim_reg_bus_adapter_pkg, not in prim_subreg_pkg.
- One combinational sub-module, prim_reg_wmask: takes policy, be, wdata and qs, and produces the merged wd. It is reused by future multi-beat adapters.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst_i for 2 cycles, then release.
  - Response: all outputs 0 during reset; req_ready_o = 1 in the first cycle after release.
- RW partial write:
  - Stimulus: idx 1, qs = 0xAABBCCDD, write 0x11223344 with be = 0b0101.
  - Response: reg_we_o = 0x02 at T+1, reg_wd_o = 0xAA22CC44, rsp_valid_o at T+2, error = 0.
- W1C and W0C partial writes:
  - Stimulus: idx 2 (W1C) write 0xFFFFFFFF with be = 0b0001; then idx 3 (W0C) write 0x00000000 with be = 0b0001.
  - Response: reg_wd_o = 0x000000FF, then 0xFFFFFF00.
- RO and RC policy checks:
  - Stimulus: write to idx 4 (RO); then read idx 5 (RC) with qs = 0x5A.
  - Response: RO write gives error = 1 with no we strobe. RC read gives reg_re_o = 0x20, rdata = 0x5A, error = 0.
- Decode errors and WO read:
  - Stimulus: misaligned address 0x06; address 0x20 with NumRegs = 8; read of a WO register.
  - Response: first two give error = 1, rdata = 0, no strobes. WO read gives rdata = 0, error = 0, with a re strobe.
- Backpressure and mid-transaction reset:
  - Stimulus: hold rsp_ready_i = 0 for 5 cycles; separately, assert rst_i during ACCESS.
  - Response: under backpressure rsp_valid_o, rdata and error are held and req_ready_o = 0 throughout. Under reset no strobe appears after reset is sampled, no response is produced, and the FSM returns to IDLE.

Source files
------------

// File: rtl/prim_reg_bus_adapter_pkg.sv
// Types private to the register bus adapter.
package prim_reg_bus_adapter_pkg;

    // One transaction walks IDLE -> ACCESS -> RESP -> IDLE.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } adapter_state_e;

    localparam int unsigned BusDW = 32;

endpackage

// File: rtl/prim_subreg_pkg.sv
// Shared software-access policy type for subreg banks and their bus front ends.
package prim_subreg_pkg;

    typedef enum logic [2:0] {
        SwAccessRW  = 3'd0,
        SwAccessRO  = 3'd1,
        SwAccessWO  = 3'd2,
        SwAccessW1C = 3'd3,
        SwAccessW1S = 3'd4,
        SwAccessW0C = 3'd5,
        SwAccessRC  = 3'd6
    } sw_access_e;

endpackage

// File: rtl/prim_reg_wmask.sv
// Byte-merge of bus write data into a register word. Unenabled bytes take a
// policy-dependent fill so that W1C/W1S/W0C registers see "no effect" there.
module prim_reg_wmask
    import prim_subreg_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  sw_access_e          policy_i,
    input  logic [DW/8-1:0]     be_i,
    input  logic [DW-1:0]       wdata_i,
    input  logic [DW-1:0]       qs_i,
    output logic [DW-1:0]       wd_o
);

    logic [DW-1:0] fill;

    // Fill word used for bytes whose enable is low.
    always_comb begin
        fill = '0;
        unique case (policy_i)
            SwAccessRW, SwAccessWO: fill = qs_i;
            SwAccessW0C:            fill = '1;
            default:                fill = '0;
        endcase
    end

    for (genvar gi = 0; gi < DW / 8; gi++) begin : gen_byte
        assign wd_o[gi*8 +: 8] = be_i[gi] ? wdata_i[gi*8 +: 8] : fill[gi*8 +: 8];
    end

endmodule

// File: rtl/prim_reg_bus_adapter.sv
// Single-outstanding valid/ready front end for a bank of subregs: policy
// checking, one-hot we/re strobes, byte-merged write data, registered response.
module prim_reg_bus_adapter
    import prim_subreg_pkg::*;
    import prim_reg_bus_adapter_pkg::*;
#(
    parameter int unsigned NumRegs = 8,
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 8,
    parameter sw_access_e  RegAccess [NumRegs] = '{default: SwAccessRW}
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [AW-1:0]         req_addr_i,
    input  logic [DW-1:0]         req_wdata_i,
    input  logic [DW/8-1:0]       req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DW-1:0]         rsp_rdata_o,
    output logic                  rsp_error_o,
    output logic [NumRegs-1:0]    reg_we_o,
    output logic [NumRegs-1:0]    reg_re_o,
    output logic [DW-1:0]         reg_wd_o,
    input  logic [NumRegs*DW-1:0] reg_qs_i
);

    localparam int unsigned IW = AW - 2;

    if ((NumRegs < 1) || (NumRegs > (1 << (AW - 2))) || (DW != BusDW)) begin : gen_param_check
        $fatal(1, "prim_reg_bus_adapter: bad NumRegs/AW/DW combination");
    end

    adapter_state_e  state_q, state_d;
    logic            write_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] be_q;
    logic [DW-1:0]   rdata_q;
    logic            error_q;

    logic            ready_raw;
    logic            capture;
    logic            in_access;
    logic [IW-1:0]   idx;
    logic            idx_ok;
    logic            wr_allowed;
    logic            we_any;
    logic            re_any;
    logic            acc_error;
    logic [DW-1:0]   acc_rdata;
    logic [DW-1:0]   qs_sel;
    sw_access_e      pol_sel;
    logic [DW-1:0]   merged_wd;

    // State register; reset aborts whatever transaction is in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_d   = state_q;
        ready_raw = 1'b0;
        capture   = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready_raw = 1'b1;
                if (req_valid_i) begin
                    capture = 1'b1;
                    state_d = StAccess;
                end
            end
            StAccess: state_d = StResp;
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Request capture on accept and response capture during ACCESS.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            if (capture) begin
                write_q <= req_write_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                be_q    <= req_be_i;
            end
            if (state_q == StAccess) begin
                rdata_q <= acc_rdata;
                error_q <= acc_error;
            end
        end
    end

    assign idx    = addr_q[AW-1:2];
    assign idx_ok = (addr_q[1:0] == 2'b00) && (32'(idx) < NumRegs);

    // Select the addressed register's value and policy; out-of-range stays benign.
    always_comb begin
        qs_sel  = '0;
        pol_sel = SwAccessRW;
        for (int i = 0; i < int'(NumRegs); i++) begin
            if (32'(idx) == 32'(i)) begin
                qs_sel  = reg_qs_i[i*DW +: DW];
                pol_sel = RegAccess[i];
            end
        end
    end

    assign wr_allowed = !(pol_sel inside {SwAccessRO, SwAccessRC});
    assign in_access  = (state_q == StAccess) && !rst_i;
    assign we_any     = in_access && write_q && idx_ok && wr_allowed && (be_q != '0);
    assign re_any     = in_access && !write_q && idx_ok;
    assign acc_error  = !idx_ok || (write_q && !wr_allowed);
    assign acc_rdata  = (!write_q && idx_ok && (pol_sel != SwAccessWO)) ? qs_sel : '0;

    prim_reg_wmask #(
        .DW (DW)
    ) u_wmask (
        .policy_i (pol_sel),
        .be_i     (be_q),
        .wdata_i  (wdata_q),
        .qs_i     (qs_sel),
        .wd_o     (merged_wd)
    );

    for (genvar gi = 0; gi < NumRegs; gi++) begin : gen_strobe
        assign reg_we_o[gi] = we_any && (32'(idx) == 32'(gi));
        assign reg_re_o[gi] = re_any && (32'(idx) == 32'(gi));
    end

    assign reg_wd_o    = (in_access && write_q) ? merged_wd : '0;
    assign req_ready_o = ready_raw && !rst_i;
    assign rsp_valid_o = (state_q == StResp) && !rst_i;
    assign rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
    assign rsp_error_o = rsp_valid_o && error_q;

endmodule

// File: tb/tb_prim_reg_bus_adapter.sv
// Self-checking bench: directed vector table, backpressure and reset corner
// cases, then randomized traffic against a behavioural access model.
module tb_prim_reg_bus_adapter;
    import prim_subreg_pkg::*;

    localparam int NR = 8;
    localparam sw_access_e POL [NR] = '{SwAccessRW, SwAccessRW, SwAccessW1C, SwAccessW0C,
                                        SwAccessRO, SwAccessRC, SwAccessWO, SwAccessW1S};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [7:0]    req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic [3:0]    req_be = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_rdata;
    logic          rsp_error;
    logic [NR-1:0] reg_we, reg_re;
    logic [31:0]   reg_wd;
    logic [NR*32-1:0] reg_qs;
    logic [31:0]   qs_mem [NR];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) reg_qs[i*32 +: 32] = qs_mem[i];
    end

    prim_reg_bus_adapter #(
        .NumRegs   (NR),
        .DW        (32),
        .AW        (8),
        .RegAccess (POL)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_error_o (rsp_error),
        .reg_we_o    (reg_we),
        .reg_re_o    (reg_re),
        .reg_wd_o    (reg_wd),
        .reg_qs_i    (reg_qs)
    );

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] qs;
        logic [7:0]  we;
        logic [7:0]  re;
        logic [31:0] wd;
        logic [31:0] rd;
        bit          err;
        bit          chk_wd;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected result of one access, derived from the access rules with word masks.
    function automatic void model(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] be, output logic [7:0] we, output logic [7:0] re,
                                  output logic [31:0] wd, output logic [31:0] rd, output bit err,
                                  output bit chk_wd);
        int idx = int'(addr) / 4;
        bit decoded = (addr % 4 == 0) && (idx < NR);
        logic [31:0] mask, fillw;
        sw_access_e p;
        we = 0; re = 0; wd = 0; rd = 0; err = 0; chk_wd = 1;
        if (!decoded) begin
            err = 1; chk_wd = !wr;
            return;
        end
        p = POL[idx];
        if (!wr) begin
            re = 8'(1 << idx);
            rd = (p == SwAccessWO) ? 32'h0 : qs_mem[idx];
            return;
        end
        if (p == SwAccessRO || p == SwAccessRC) begin
            err = 1; chk_wd = 0;
            return;
        end
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        if (p == SwAccessRW || p == SwAccessWO) fillw = qs_mem[idx];
        else if (p == SwAccessW0C)              fillw = 32'hFFFF_FFFF;
        else                                    fillw = 32'h0;
        wd = (wdata & mask) | (fillw & ~mask);
        if (be != 0) we = 8'(1 << idx);
    endfunction

    // One full transaction with protocol timing checks; hold = backpressure cycles.
    task automatic run_txn(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int hold,
                           output logic [7:0] g_we, output logic [7:0] g_re, output logic [31:0] g_wd,
                           output logic [31:0] g_rd, output logic g_err);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_idle", req_ready, 1);
        req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk);
        #1;
        // Junk on the request bus while not ready must be ignored.
        req_write = 1'($urandom); req_addr = 8'($urandom); req_wdata = $urandom; req_be = 4'($urandom);
        @(negedge clk);
        g_we = reg_we; g_re = reg_re; g_wd = reg_wd;
        check("ready_access", req_ready, 0);
        check("valid_access", rsp_valid, 0);
        @(negedge clk);
        req_valid = 0;
        check("rsp_valid", rsp_valid, 1);
        check("strobe_off_resp", {reg_we, reg_re}, 0);
        check("wd_off_resp", reg_wd, 0);
        check("ready_resp", req_ready, 0);
        g_rd = rsp_rdata; g_err = rsp_error;
        for (int h = 0; h < hold; h++) begin
            qs_mem[$urandom_range(0, NR-1)] = $urandom;
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, g_rd);
            check("hold_error", rsp_error, g_err);
            check("hold_ready", req_ready, 0);
        end
        rsp_ready = 1;
        @(posedge clk);
        #1;
        rsp_ready = 0;
    endtask

    task automatic exec_and_check(input int id, input bit wr, input logic [7:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] be, input int hold);
        logic [7:0] e_we, e_re, g_we, g_re;
        logic [31:0] e_wd, e_rd, g_wd, g_rd;
        bit e_err, chk_wd;
        logic g_err;
        model(wr, addr, wdata, be, e_we, e_re, e_wd, e_rd, e_err, chk_wd);
        run_txn(wr, addr, wdata, be, hold, g_we, g_re, g_wd, g_rd, g_err);
        check("we", g_we, e_we);
        check("re", g_re, e_re);
        if (chk_wd) check("wd", g_wd, e_wd);
        check("rdata", g_rd, e_rd);
        check("error", g_err, e_err);
        $display("txn %0d: wr=%0d addr=%02h wdata=%08h be=%01h -> we=%02h re=%02h wd=%08h rdata=%08h err=%0d",
                 id, wr, addr, wdata, be, g_we, g_re, g_wd, g_rd, g_err);
    endtask

    initial begin
        logic [7:0] g_we, g_re;
        logic [31:0] g_wd, g_rd;
        logic g_err;
        logic [7:0] e_we, e_re;
        logic [31:0] e_wd, e_rd;
        bit e_err, chk_wd;

        for (int i = 0; i < NR; i++) qs_mem[i] = 32'h0;

        //             wr  addr   wdata         be    qs            we     re     wd            rd            err chk_wd
        vecs[0]  = '{1, 8'h04, 32'h11223344, 4'h5, 32'hAABBCCDD, 8'h02, 8'h00, 32'hAA22CC44, 32'h0,        0, 1};
        vecs[1]  = '{1, 8'h08, 32'hFFFFFFFF, 4'h1, 32'h12345678, 8'h04, 8'h00, 32'h000000FF, 32'h0,        0, 1};
        vecs[2]  = '{1, 8'h0C, 32'h00000000, 4'h1, 32'h12345678, 8'h08, 8'h00, 32'hFFFFFF00, 32'h0,        0, 1};
        vecs[3]  = '{1, 8'h10, 32'h00001234, 4'hF, 32'h00000077, 8'h00, 8'h00, 32'h0,        32'h0,        1, 0};
        vecs[4]  = '{0, 8'h14, 32'h0,        4'h0, 32'h0000005A, 8'h00, 8'h20, 32'h0,        32'h0000005A, 0, 1};
        vecs[5]  = '{0, 8'h06, 32'h0,        4'h0, 32'h55555555, 8'h00, 8'h00, 32'h0,        32'h0,        1, 1};
        vecs[6]  = '{0, 8'h20, 32'h0,        4'h0, 32'h0,        8'h00, 8'h00, 32'h0,        32'h0,        1, 1};
        vecs[7]  = '{0, 8'h18, 32'h0,        4'h0, 32'hDEADBEEF, 8'h00, 8'h40, 32'h0,        32'h0,        0, 1};
        vecs[8]  = '{1, 8'h00, 32'h99999999, 4'h0, 32'h01020304, 8'h00, 8'h00, 32'h01020304, 32'h0,        0, 1};
        vecs[9]  = '{1, 8'h1C, 32'h0000FF00, 4'h2, 32'hFFFFFFFF, 8'h80, 8'h00, 32'h0000FF00, 32'h0,        0, 1};
        vecs[10] = '{0, 8'h00, 32'h0,        4'h0, 32'hCAFEF00D, 8'h00, 8'h01, 32'h0,        32'hCAFEF00D, 0, 1};
        vecs[11] = '{1, 8'h14, 32'hFFFFFFFF, 4'hF, 32'h0000005A, 8'h00, 8'h00, 32'h0,        32'h0,        1, 0};
        vecs[12] = '{1, 8'h05, 32'hFFFFFFFF, 4'hF, 32'h0,        8'h00, 8'h00, 32'h0,        32'h0,        1, 0};

        // Reset held two cycles: every output must be 0.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_outputs", {req_ready, rsp_valid, rsp_rdata, rsp_error, reg_we, reg_re}, 0);
            check("rst_wd", reg_wd, 0);
        end
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("ready_after_reset", req_ready, 1);

        // Directed vector table.
        for (int v = 0; v < 13; v++) begin
            if ((int'(vecs[v].addr) / 4) < NR) qs_mem[int'(vecs[v].addr) / 4] = vecs[v].qs;
            run_txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].be, 0, g_we, g_re, g_wd, g_rd, g_err);
            check("vec_we", g_we, vecs[v].we);
            check("vec_re", g_re, vecs[v].re);
            if (vecs[v].chk_wd) check("vec_wd", g_wd, vecs[v].wd);
            check("vec_rdata", g_rd, vecs[v].rd);
            check("vec_error", g_err, vecs[v].err);
            $display("vec %0d: wr=%0d addr=%02h -> we=%02h re=%02h wd=%08h rdata=%08h err=%0d",
                     v, vecs[v].wr, vecs[v].addr, g_we, g_re, g_wd, g_rd, g_err);
        end

        // Backpressure: response held 5 cycles while register values change underneath.
        qs_mem[1] = 32'h11112222;
        exec_and_check(100, 0, 8'h04, 32'h0, 4'h0, 5);
        qs_mem[4] = 32'h0BADF00D;
        exec_and_check(101, 1, 8'h10, 32'h1, 4'hF, 5);

        // Reset asserted during ACCESS aborts the write.
        @(negedge clk);
        qs_mem[1] = 32'h0;
        req_valid = 1; req_write = 1; req_addr = 8'h04; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 0;
        rst = 1;
        @(negedge clk);
        check("rst_access_we", reg_we, 0);
        check("rst_access_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("post_rst_strobes", {reg_we, reg_re}, 0);
        check("post_rst_valid", rsp_valid, 0);
        check("post_rst_ready", req_ready, 1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("no_rsp_after_abort", rsp_valid, 0);
        end
        $display("abort: reset during ACCESS, ready=%0d valid=%0d", req_ready, rsp_valid);

        // Randomized traffic against the model.
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < NR; i++) qs_mem[i] = $urandom;
            exec_and_check(200 + t, 1'($urandom), 8'($urandom_range(0, 35)), $urandom,
                           4'($urandom), (t % 7 == 0) ? 2 : 0);
        end

        // Model spot check independent of DUT: reading an in-range RW register.
        model(0, 8'h00, 32'h0, 4'h0, e_we, e_re, e_wd, e_rd, e_err, chk_wd);
        run_txn(0, 8'h00, 32'h0, 4'h0, 0, g_we, g_re, g_wd, g_rd, g_err);
        check("final_rdata", g_rd, e_rd);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
